// File: rtl/gpio_nios_memory_arbiter.sv
// Two-master arbiter for a shared single-port on-chip RAM with burst lock and a one-stage read return tag.
// Define GPIO_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise master 0 has fixed priority.
module gpio_nios_memory_arbiter #(
   parameter int DEPTH     = 5000,
   parameter int BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [12:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [12:0] mem_address,
   output logic [3:0]  mem_byteenable,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic        mem_clken,
   input  logic [31:0] mem_readdata
);

   localparam int              CNT_W     = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
   localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);

   logic             req0, req1;
   logic             gnt0, gnt1, accept;
   logic             lock_ok;
   logic             last_grant;
   logic [CNT_W-1:0] burst_cnt;

   logic [12:0]      sel_address;
   logic [3:0]       sel_byteenable;
   logic [31:0]      sel_writedata;
   logic             sel_write;
   logic             in_range;

   logic             vld_p1;
   logic             id_p1;
   logic             oor_p1;
   logic             rvalid0, rvalid1;

   assign req0   = m0_read | m0_write;
   assign req1   = m1_read | m1_write;
   assign accept = gnt0 | gnt1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
`ifdef GPIO_MEM_ARB_ROUND_ROBIN_EN
      lock_ok = 1'b1;
`else
      // Under fixed priority only master 0 can hold a burst; master 1 gets single slots.
      lock_ok = ~last_grant;
`endif
      if (!reset) begin
         if (req0 && !req1) begin
            gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            if (burst_cnt != '0 && burst_cnt < BURST_LIM && lock_ok) begin
               gnt0 = ~last_grant;
               gnt1 = last_grant;
            end else if (burst_cnt >= BURST_LIM) begin
               gnt0 = last_grant;
               gnt1 = ~last_grant;
            end else begin
`ifdef GPIO_MEM_ARB_ROUND_ROBIN_EN
               gnt0 = last_grant;
               gnt1 = ~last_grant;
`else
               gnt0 = 1'b1;
`endif
            end
         end
      end
   end

   always_comb begin
      sel_address    = '0;
      sel_byteenable = '0;
      sel_writedata  = '0;
      sel_write      = 1'b0;
      if (gnt1) begin
         sel_address    = m1_address;
         sel_byteenable = m1_byteenable;
         sel_writedata  = m1_writedata;
         sel_write      = m1_write;
      end else if (gnt0) begin
         sel_address    = m0_address;
         sel_byteenable = m0_byteenable;
         sel_writedata  = m0_writedata;
         sel_write      = m0_write;
      end
   end

   assign in_range       = ({19'd0, sel_address} < DEPTH_U);
   assign mem_address    = sel_address;
   assign mem_byteenable = sel_byteenable;
   assign mem_writedata  = sel_writedata;
   assign mem_chipselect = accept & in_range;
   assign mem_write      = accept & in_range & sel_write;
   assign mem_clken      = 1'b1;

   assign m0_waitrequest = ~gnt0;
   assign m1_waitrequest = ~gnt1;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         burst_cnt  <= '0;
      end else if (accept) begin
         if (gnt1 == last_grant) begin
            burst_cnt <= (burst_cnt >= BURST_LIM) ? BURST_LIM : burst_cnt + CNT_W'(1);
         end else begin
            burst_cnt <= CNT_W'(1);
         end
         last_grant <= gnt1;
      end else begin
         burst_cnt <= '0;
      end
   end

   // ---- stage p1: read return tag, aligned with the RAM's one-cycle latency ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= accept & ~sel_write;
      end
   end

   always_ff @(posedge clk) begin
      id_p1  <= gnt1;
      oor_p1 <= ~in_range;
   end

   assign rvalid0 = vld_p1 & ~id_p1 & ~reset;
   assign rvalid1 = vld_p1 & id_p1 & ~reset;

   assign m0_readdatavalid = rvalid0;
   assign m1_readdatavalid = rvalid1;
   assign m0_readdata      = (rvalid0 && !oor_p1) ? mem_readdata : 32'h0;
   assign m1_readdata      = (rvalid1 && !oor_p1) ? mem_readdata : 32'h0;

endmodule

// File: tb/tb_gpio_nios_memory_arbiter.sv
// Scoreboard bench for gpio_nios_memory_arbiter: directed cases plus randomized two-master traffic
// checked against a transaction-level reference model with its own shadow memory.
module tb_gpio_nios_memory_arbiter;

   localparam int DEPTH = 5000;
   localparam int BURST = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = 32'h0;

   always #5 clk = ~clk;

   gpio_nios_memory_arbiter #(.DEPTH(DEPTH), .BURST_MAX(BURST)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // RAM seen by the DUT, one-cycle read latency
   logic [31:0] ram [DEPTH];
   // Shadow memory of the reference model
   logic [31:0] ref_mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
   end

   always @(posedge clk) begin
      if (mem_chipselect && (32'(mem_address) < DEPTH)) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   // Reference model: arbitration rules evaluated per cycle, expected read data queued per master
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   int          own, run, g;
   bit          r0, r1, hold, inr, w;
   logic [12:0] a;
   logic [3:0]  be;
   logic [31:0] d;

   always @(negedge clk) begin
      if (reset) begin
         check("rst_wait0", m0_waitrequest, 1);
         check("rst_wait1", m1_waitrequest, 1);
         check("rst_cs", mem_chipselect, 0);
         check("rst_mwrite", mem_write, 0);
         check("rst_rdv0", m0_readdatavalid, 0);
         check("rst_rdv1", m1_readdatavalid, 0);
         own = 1;
         run = 0;
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         r0 = m0_read | m0_write;
         r1 = m1_read | m1_write;
         if (r0 && r1) begin
            hold = (run > 0) && (run < BURST);
`ifndef GPIO_MEM_ARB_ROUND_ROBIN_EN
            if (own == 1) hold = 0;
`endif
            if (hold) g = own;
            else if (run >= BURST) g = 1 - own;
            else begin
`ifdef GPIO_MEM_ARB_ROUND_ROBIN_EN
               g = 1 - own;
`else
               g = 0;
`endif
            end
         end else if (r0) g = 0;
         else if (r1) g = 1;
         else g = -1;

         check("wait0", m0_waitrequest, (g != 0));
         check("wait1", m1_waitrequest, (g != 1));
         if (g >= 0) begin
            a   = (g == 1) ? m1_address : m0_address;
            be  = (g == 1) ? m1_byteenable : m0_byteenable;
            d   = (g == 1) ? m1_writedata : m0_writedata;
            w   = (g == 1) ? m1_write : m0_write;
            inr = (32'(a) < DEPTH);
            check("mem_cs", mem_chipselect, inr);
            check("mem_write", mem_write, inr && w);
            if (inr) check("mem_addr", mem_address, a);
            if (w) begin
               if (inr)
                  for (int b = 0; b < 4; b++)
                     if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else if (g == 0) begin
               exp_q0.push_back(inr ? ref_mem[a] : 32'h0);
            end else begin
               exp_q1.push_back(inr ? ref_mem[a] : 32'h0);
            end
            if (g == own) run = (run < BURST) ? run + 1 : BURST;
            else begin
               own = g;
               run = 1;
            end
         end else begin
            check("idle_cs", mem_chipselect, 0);
            check("idle_mwrite", mem_write, 0);
            run = 0;
         end
      end
   end

   // Monitor: compares returned read data whenever the DUT strobes readdatavalid
   always @(negedge clk) begin
      if (!reset) begin
         if (m0_readdatavalid) begin
            if (exp_q0.size() == 0) check("m0_rdv_unexpected", m0_readdatavalid, 0);
            else check("m0_rdata", m0_readdata, exp_q0.pop_front());
         end else begin
            check("m0_rdata_idle", m0_readdata, 0);
         end
         if (m1_readdatavalid) begin
            if (exp_q1.size() == 0) check("m1_rdv_unexpected", m1_readdatavalid, 0);
            else check("m1_rdata", m1_readdata, exp_q1.pop_front());
         end else begin
            check("m1_rdata_idle", m1_readdata, 0);
         end
      end else begin
         check("rst_rdata0", m0_readdata, 0);
         check("rst_rdata1", m1_readdata, 0);
      end
   end

   // Grant log for the directed contention pattern
   bit log_en = 0;
   int act_log[$];
   always @(negedge clk)
      if (log_en && !reset)
         act_log.push_back(!m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic drive(input int m, input bit rd, input bit wr, input logic [12:0] ad,
                        input logic [3:0] bee, input logic [31:0] dat);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = ad; m0_byteenable = bee; m0_writedata = dat;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = ad; m1_byteenable = bee; m1_writedata = dat;
      end
   endtask

   function automatic logic [12:0] rand_addr();
      case ($urandom % 8)
         0:       return 13'd4999;
         1:       return 13'd5000;
         2:       return 13'd8191;
         default: return 13'($urandom % 16);
      endcase
   endfunction

   int exp_pat[10];

   initial begin
      reset = 1;
      idle_all();
      repeat (3) step();
      reset = 0;
      @(negedge clk);
      check("clken", mem_clken, 1);
      check("idle_wait0", m0_waitrequest, 1);
      step();

      // single-master write then read back
      drive(0, 0, 1, 13'h010, 4'hF, 32'hA5A5_1234);
      step();
      drive(0, 1, 0, 13'h010, 4'hF, 32'h0);
      step();
      idle_all();
      @(negedge clk);
      check("wr_rd_rdv", m0_readdatavalid, 1);
      check("wr_rd_data", m0_readdata, 32'hA5A5_1234);
      step();

      // byte-lane write
      drive(0, 0, 1, 13'h020, 4'hF, 32'h1122_3344);
      step();
      drive(0, 0, 1, 13'h020, 4'h1, 32'h0000_00FF);
      step();
      idle_all();
      drive(1, 1, 0, 13'h020, 4'hF, 32'h0);
      step();
      idle_all();
      @(negedge clk);
      check("byte_rdv", m1_readdatavalid, 1);
      check("byte_data", m1_readdata, 32'h1122_33FF);
      step();

      // out-of-range access
      drive(1, 0, 1, 13'd5000, 4'hF, 32'hFFFF_FFFF);
      @(negedge clk);
      check("oor_wr_accept", m1_waitrequest, 0);
      check("oor_wr_cs", mem_chipselect, 0);
      step();
      drive(1, 1, 0, 13'd5000, 4'hF, 32'h0);
      @(negedge clk);
      check("oor_rd_accept", m1_waitrequest, 0);
      check("oor_rd_cs", mem_chipselect, 0);
      step();
      idle_all();
      @(negedge clk);
      check("oor_rdv", m1_readdatavalid, 1);
      check("oor_data", m1_readdata, 0);
      step();

      // reset arriving while a read is in flight and another is requested
      drive(0, 1, 0, 13'h003, 4'hF, 32'h0);
      step();
      reset = 1;
      @(negedge clk);
      check("rr_rdv_gate", m0_readdatavalid, 0);
      check("rr_wait0", m0_waitrequest, 1);
      check("rr_wait1", m1_waitrequest, 1);
      step();
      @(negedge clk);
      check("rr_rdv_next", m0_readdatavalid, 0);
      check("rr_wait0_b", m0_waitrequest, 1);
      step();

      // contention from reset release
      drive(0, 1, 0, 13'h001, 4'hF, 32'h0);
      drive(1, 1, 0, 13'h002, 4'hF, 32'h0);
      step();
      reset = 0;
      log_en = 1;
      repeat (10) step();
      log_en = 0;
      idle_all();
`ifdef GPIO_MEM_ARB_ROUND_ROBIN_EN
      exp_pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`else
      exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
      check("arb_log_len", act_log.size(), 10);
      for (int i = 0; i < 10 && i < act_log.size(); i++)
         check($sformatf("arb_cycle%0d", i), act_log[i], exp_pat[i]);
      repeat (2) step();

      // randomized traffic with occasional resets
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom % 128 == 0);
         for (int m = 0; m < 2; m++) begin
            case ($urandom % 4)
               0:       drive(m, 0, 0, rand_addr(), 4'($urandom), $urandom);
               1:       drive(m, 0, 1, rand_addr(), 4'($urandom), $urandom);
               2:       drive(m, 1, ($urandom % 8 == 0), rand_addr(), 4'($urandom), $urandom);
               default: drive(m, 1, 0, rand_addr(), 4'($urandom), $urandom);
            endcase
         end
         step();
      end
      reset = 0;
      idle_all();
      repeat (3) step();
      check("drain_q0", exp_q0.size(), 0);
      check("drain_q1", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
